// File: rtl/fp_minmax_seq.sv
// Running min/max tracker for a stream of FP32 values, driving one external
// fp_comp-style comparator and reporting min, max, count and exception status.
module fp_minmax_seq #(
  parameter int CMP_LAT = 2,
  parameter int TIMEOUT = 15,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [31:0]   cmp_in1,
  output logic [31:0]   cmp_in2,
  output logic          cmp_act,
  input  logic          cmp_eq,
  input  logic          cmp_great,
  input  logic          cmp_less,
  input  logic          cmp_done,
  input  logic          cmp_inv,
  output logic [31:0]   res_min,
  output logic [31:0]   res_max,
  output logic [CW-1:0] res_count,
  output logic          res_inv,
  output logic          res_err,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    MIN_ISS,
    MIN_WAIT,
    MAX_ISS,
    MAX_WAIT,
    DRAIN,
    RESULT
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     cmp_in1_reg, cmp_in1_next;
  logic [31:0]     cmp_in2_reg, cmp_in2_next;
  logic [31:0]     min_reg, min_next;
  logic [31:0]     max_reg, max_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            inv_reg, inv_next;
  logic            err_reg, err_next;
  logic            first_reg, first_next;
  logic            last_reg, last_next;
  logic [WW-1:0]   w_reg, w_next;

  logic            sample_ok;
  logic            timed_out;
  logic [CW-1:0]   count_inc;
  state_t          after_elem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cmp_in1_reg <= '0;
      cmp_in2_reg <= '0;
      min_reg     <= '0;
      max_reg     <= '0;
      count_reg   <= '0;
      inv_reg     <= 1'b0;
      err_reg     <= 1'b0;
      first_reg   <= 1'b1;
      last_reg    <= 1'b0;
      w_reg       <= '0;
    end else begin
      state_reg   <= state_next;
      cmp_in1_reg <= cmp_in1_next;
      cmp_in2_reg <= cmp_in2_next;
      min_reg     <= min_next;
      max_reg     <= max_next;
      count_reg   <= count_next;
      inv_reg     <= inv_next;
      err_reg     <= err_next;
      first_reg   <= first_next;
      last_reg    <= last_next;
      w_reg       <= w_next;
    end
  end

  // Results before CMP_LAT-1 wait cycles may still belong to the previous request.
  assign sample_ok  = (w_reg >= WW'(CMP_LAT - 1)) && cmp_done;
  assign timed_out  = (w_reg >= WW'(TIMEOUT - 1));
  assign count_inc  = (count_reg == {CW{1'b1}}) ? count_reg : count_reg + 1'b1;
  assign after_elem = last_reg ? RESULT : IDLE;

  always_comb begin
    state_next   = state_reg;
    cmp_in1_next = cmp_in1_reg;
    cmp_in2_next = cmp_in2_reg;
    min_next     = min_reg;
    max_next     = max_reg;
    count_next   = count_reg;
    inv_next     = inv_reg;
    err_next     = err_reg;
    first_next   = first_reg;
    last_next    = last_reg;
    w_next       = w_reg;

    in_ready  = (state_reg == IDLE) || (state_reg == DRAIN);
    cmp_act   = (state_reg == MIN_ISS) || (state_reg == MAX_ISS);
    res_valid = (state_reg == RESULT);

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          count_next = count_inc;
          last_next  = in_last;
          if (first_reg) begin
            min_next   = in_data;
            max_next   = in_data;
            first_next = 1'b0;
            if (in_last) state_next = RESULT;
          end else begin
            cmp_in1_next = in_data;
            cmp_in2_next = min_reg;
            state_next   = MIN_ISS;
          end
        end
      end

      MIN_ISS: begin
        w_next     = '0;
        state_next = MIN_WAIT;
      end

      // A done with no relation flag is malformed and treated as invalid.
      MIN_WAIT: begin
        if (sample_ok) begin
          if (cmp_inv) begin
            inv_next   = 1'b1;
            state_next = after_elem;
          end else if (cmp_less) begin
            min_next   = cmp_in1_reg;
            state_next = after_elem;
          end else if (cmp_eq || cmp_great) begin
            cmp_in2_next = max_reg;
            state_next   = MAX_ISS;
          end else begin
            inv_next   = 1'b1;
            state_next = after_elem;
          end
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = last_reg ? RESULT : DRAIN;
        end else begin
          w_next = w_reg + 1'b1;
        end
      end

      MAX_ISS: begin
        w_next     = '0;
        state_next = MAX_WAIT;
      end

      MAX_WAIT: begin
        if (sample_ok) begin
          if (cmp_inv) begin
            inv_next = 1'b1;
          end else if (cmp_great) begin
            max_next = cmp_in1_reg;
          end else if (!(cmp_eq || cmp_less)) begin
            inv_next = 1'b1;
          end
          state_next = after_elem;
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = last_reg ? RESULT : DRAIN;
        end else begin
          w_next = w_reg + 1'b1;
        end
      end

      DRAIN: begin
        if (in_valid) begin
          count_next = count_inc;
          if (in_last) state_next = RESULT;
        end
      end

      RESULT: begin
        if (res_ready) begin
          state_next = IDLE;
          count_next = '0;
          first_next = 1'b1;
          inv_next   = 1'b0;
          err_next   = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign cmp_in1   = cmp_in1_reg;
  assign cmp_in2   = cmp_in2_reg;
  assign res_min   = min_reg;
  assign res_max   = max_reg;
  assign res_count = count_reg;
  assign res_inv   = inv_reg;
  assign res_err   = err_reg;

endmodule

// File: tb/tb_fp_minmax_seq.sv
// Self-checking bench for fp_minmax_seq: a 2-cycle comparator model plus a
// sequence-level reference model of min/max/count/inv/err.
module tb_fp_minmax_seq;
  localparam int CMP_LAT = 2;
  localparam int TIMEOUT = 15;
  localparam int CW      = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [31:0]   cmp_in1, cmp_in2;
  logic          cmp_act;
  logic          cmp_eq = 1'b0, cmp_great = 1'b0, cmp_less = 1'b0;
  logic          cmp_done = 1'b0, cmp_inv = 1'b0;
  logic [31:0]   res_min, res_max;
  logic [CW-1:0] res_count;
  logic          res_inv, res_err, res_valid;
  logic          res_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int act_total = 0;
  int issued_elem = 0;
  int hang_elem = 0;
  logic [31:0] seq_q[$];

  always #5 clk = ~clk;

  fp_minmax_seq #(.CMP_LAT(CMP_LAT), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_act(cmp_act),
    .cmp_eq(cmp_eq), .cmp_great(cmp_great), .cmp_less(cmp_less),
    .cmp_done(cmp_done), .cmp_inv(cmp_inv),
    .res_min(res_min), .res_max(res_max), .res_count(res_count),
    .res_inv(res_inv), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready)
  );

  // IEEE-754 ordering: 2 = unordered (NaN), else -1/0/1 for a<b, a==b, a>b.
  function automatic int fcmp(input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 2;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    if (ka < kb) return -1;
    if (ka > kb) return 1;
    return 0;
  endfunction

  // Comparator: result lands two cycles after the request; old flags linger
  // for the cycle in between, and a hung element never gets done.
  logic [31:0] op1 = '0, op2 = '0;
  logic stage = 1'b0, hang_now = 1'b0;
  always @(posedge clk) begin
    if (cmp_act) begin
      act_total <= act_total + 1;
      op1       <= cmp_in1;
      op2       <= cmp_in2;
      hang_now  <= (issued_elem == hang_elem);
      stage     <= 1'b1;
    end else begin
      stage <= 1'b0;
    end
    if (stage) begin
      if (hang_now) begin
        cmp_done <= 1'b0;
      end else begin
        cmp_done  <= 1'b1;
        cmp_inv   <= (fcmp(op1, op2) == 2);
        cmp_less  <= (fcmp(op1, op2) == -1);
        cmp_eq    <= (fcmp(op1, op2) == 0);
        cmp_great <= (fcmp(op1, op2) == 1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input int hang_at, output logic [31:0] emin, output logic [31:0] emax,
                       output int ecnt, output logic einv, output logic eerr,
                       output int eacts, output int elast);
    bit first = 1'b1;
    int c, acts_this;
    emin = '0; emax = '0; ecnt = 0; einv = 1'b0; eerr = 1'b0; eacts = 0; elast = 0;
    foreach (seq_q[i]) begin
      acts_this = 0;
      ecnt++;
      if (!eerr) begin
        if (first) begin
          emin = seq_q[i]; emax = seq_q[i]; first = 1'b0;
        end else begin
          acts_this = 1;
          if (hang_at == i + 1) begin
            eerr = 1'b1;
          end else begin
            c = fcmp(seq_q[i], emin);
            if (c == 2) einv = 1'b1;
            else if (c < 0) emin = seq_q[i];
            else begin
              acts_this = 2;
              c = fcmp(seq_q[i], emax);
              if (c == 2) einv = 1'b1;
              else if (c > 0) emax = seq_q[i];
            end
          end
        end
      end
      eacts += acts_this;
      elast = acts_this;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int idx);
    int n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    issued_elem = idx;
  endtask

  task automatic wait_result(input int budget);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_wait", {31'b0, res_valid}, 32'd1);
  endtask

  task automatic consume();
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'b0, res_valid}, 32'd0);
    chk("post_ready", {31'b0, in_ready}, 32'd1);
    chk("post_count", 32'(res_count), 32'd0);
    chk("post_inv", {31'b0, res_inv}, 32'd0);
    chk("post_err", {31'b0, res_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_cmp_act", {31'b0, cmp_act}, 32'd0);
    chk("rst_cmp_in1", cmp_in1, 32'd0);
    chk("rst_cmp_in2", cmp_in2, 32'd0);
    chk("rst_min", res_min, 32'd0);
    chk("rst_max", res_max, 32'd0);
    chk("rst_count", 32'(res_count), 32'd0);
    chk("rst_flags", {29'b0, res_inv, res_err, res_valid}, 32'd0);
  endtask

  task automatic run_seq(input int hang_at, input int gap_max, input int budget, input bit release_it);
    logic [31:0] emin, emax;
    logic einv, eerr;
    int ecnt, eacts, elast, base, last_base, gap;
    model(hang_at, emin, emax, ecnt, einv, eerr, eacts, elast);
    hang_elem = hang_at;
    base = act_total;
    last_base = act_total;
    foreach (seq_q[i]) begin
      gap = $urandom_range(0, gap_max);
      repeat (gap) begin @(posedge clk); #1; end
      send(seq_q[i], (i == seq_q.size() - 1), i + 1);
      if (i == seq_q.size() - 1) last_base = act_total;
      else if (hang_at > 0 && i + 1 > hang_at) begin
        @(negedge clk);
        chk("drain_err", {31'b0, res_err}, 32'd1);
        chk("drain_no_valid", {31'b0, res_valid}, 32'd0);
        @(posedge clk); #1;
      end
    end
    wait_result(budget);
    chk("min", res_min, emin);
    chk("max", res_max, emax);
    chk("count", 32'(res_count), 32'(ecnt));
    chk("inv", {31'b0, res_inv}, {31'b0, einv});
    chk("err", {31'b0, res_err}, {31'b0, eerr});
    chk("acts_total", 32'(act_total - base), 32'(eacts));
    chk("acts_last", 32'(act_total - last_base), 32'(elast));
    chk("ready_low", {31'b0, in_ready}, 32'd0);
    if (release_it) consume();
  endtask

  function automatic logic [31:0] rand_fp(input logic [31:0] prev);
    logic [31:0] v;
    case ($urandom_range(0, 11))
      0:       v = ($urandom_range(0, 2) == 0) ? 32'h7FC00000 : 32'h3F800000;
      1:       v = 32'h00000000;
      2:       v = 32'h80000000;
      3, 4:    v = prev;
      default: v = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] prev;
    int len, hang;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;

    // 1.0, 2.0, -3.0: the final element takes only the MIN compare
    seq_q = '{32'h3F800000, 32'h40000000, 32'hC0400000};
    run_seq(0, 0, 100, 1'b1);

    // Lone element: result without any comparator request
    seq_q = '{32'h3F000000};
    run_seq(0, 0, 2, 1'b1);

    // NaN in the middle flags inv and is not recorded
    seq_q = '{32'h3F800000, 32'h7FC00000, 32'h3F000000};
    run_seq(0, 0, 100, 1'b0);

    // Result held while res_ready stays low
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_min", res_min, 32'h3F000000);
      chk("hold_max", res_max, 32'h3F800000);
      chk("hold_count", 32'(res_count), 32'd3);
      chk("hold_inv", {31'b0, res_inv}, 32'd1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;

    // Comparator hangs on element 2 of 4: timeout, then drain to the last
    seq_q = '{32'h3F800000, 32'h40400000, 32'h41000000, 32'hC1000000};
    run_seq(2, 0, 100, 1'b1);

    // +0 then -0: equal, first-seen encoding kept
    seq_q = '{32'h00000000, 32'h80000000};
    run_seq(0, 0, 100, 1'b1);

    // Randomized sequences
    for (int s = 0; s < 25; s++) begin
      len = $urandom_range(1, 6);
      seq_q.delete();
      prev = 32'h3F800000;
      for (int e = 0; e < len; e++) begin
        prev = rand_fp(prev);
        seq_q.push_back(prev);
      end
      hang = (len >= 2 && $urandom_range(0, 4) == 0) ? $urandom_range(2, len) : 0;
      run_seq(hang, 2, 200, 1'b1);
      $display("seq %0d len %0d hang %0d min %h max %h count %0d inv %0b err %0b",
               s, len, hang, res_min, res_max, res_count, res_inv, res_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
